// File: rtl/xor16b_pkg.sv
// Shared types for the XOR16B result stage: result entry layout and entry builder.
// Build option XOR16B_RESULT_PARITY_EN (used by xor16b_result_stage) selects parity storage.
package xor16b_pkg;

  localparam int unsigned XOR_WIDTH = 16;

  typedef struct packed {
    logic [XOR_WIDTH-1:0] data;
    logic                 zero;
    logic                 parity;
  } xor_result_t;

  // Builds one FIFO entry from a Cout word; parity is forced low when not kept.
  function automatic xor_result_t f_make_result(input logic [XOR_WIDTH-1:0] data,
                                                input logic                 par_en);
    xor_result_t r;
    r.data   = data;
    r.zero   = ~|data;
    r.parity = par_en & (^data);
    return r;
  endfunction

endpackage

// File: rtl/xor16b_result_fifo.sv
// Circular result FIFO for the XOR16B result stage; head is zero whenever the FIFO is empty.
// DEPTH must be a power of two so the pointers wrap naturally.
module xor16b_result_fifo
  import xor16b_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                            clkpos1,
  input  logic                            rst,
  input  logic                            i_push,
  input  logic                            i_pop,
  input  xor_result_t                     i_data,
  output xor_result_t                     o_head,
  output logic [$clog2(DEPTH+1)-1:0]      o_count,
  output logic                            o_full,
  output logic                            o_empty
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  xor_result_t    r_mem [DEPTH];
  logic [PW-1:0]  r_wr_ptr;
  logic [PW-1:0]  r_rd_ptr;
  logic [CW-1:0]  r_count;
  logic           w_full;
  logic           w_empty;
  logic           w_do_push;
  logic           w_do_pop;

  assign w_full    = (r_count == CW'(DEPTH));
  assign w_empty   = (r_count == '0);
  assign w_do_pop  = i_pop && !w_empty;
  // A push into a full FIFO only lands when the head leaves in the same cycle.
  assign w_do_push = i_push && (!w_full || w_do_pop);

  always_ff @(posedge clkpos1 or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      unique case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clkpos1) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_data;
  end

  assign o_head  = w_empty ? '0 : r_mem[r_rd_ptr];
  assign o_count = r_count;
  assign o_full  = w_full;
  assign o_empty = w_empty;

endmodule

// File: rtl/xor16b_result_stage.sv
// Capture stage behind the 16-bit XOR array: token pipe, credit-based issue throttle, result FIFO.
// Build option XOR16B_RESULT_PARITY_EN: when defined, parity is stored per entry and driven on out_parity.
module xor16b_result_stage
  import xor16b_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned LAT   = 2,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clkpos1,
  input  logic             rst,
  input  logic             issue_valid,
  output logic             issue_ready,
  input  logic [WIDTH-1:0] cout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_zero,
  output logic             out_parity,
  output logic             ovf_err
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned IW = $clog2(LAT + 1);
  localparam int unsigned SW = ((CW > IW) ? CW : IW) + 1;
`ifdef XOR16B_RESULT_PARITY_EN
  localparam logic PAR_EN = 1'b1;
`else
  localparam logic PAR_EN = 1'b0;
`endif

  logic [LAT-1:0] r_tok;
  logic           r_run;
  logic           r_ovf_err;
  logic [IW-1:0]  w_inflight;
  logic [CW-1:0]  w_count;
  logic           w_full;
  logic           w_empty;
  logic           w_accept;
  logic           w_capture;
  logic           w_pop;
  logic           w_push;
  xor_result_t    w_entry;
  xor_result_t    w_head;

  // Tokens still travelling through the array each hold a reserved FIFO slot.
  always_comb begin
    w_inflight = '0;
    for (int i = 0; i < int'(LAT); i++) begin
      w_inflight = w_inflight + IW'(r_tok[i]);
    end
  end

  assign issue_ready = r_run && ((SW'(w_count) + SW'(w_inflight)) < SW'(DEPTH));
  assign w_accept    = issue_valid && issue_ready;
  assign w_capture   = r_tok[LAT-1];
  assign w_pop       = out_valid && out_ready;
  assign w_push      = w_capture && (!w_full || w_pop);
  assign w_entry     = f_make_result(XOR_WIDTH'(cout), PAR_EN);

  // r_run holds issue off until the first clock after reset release.
  always_ff @(posedge clkpos1 or posedge rst) begin
    if (rst) begin
      r_run <= 1'b0;
      r_tok <= '0;
    end else begin
      r_run    <= 1'b1;
      r_tok[0] <= w_accept;
      for (int i = 1; i < int'(LAT); i++) begin
        r_tok[i] <= r_tok[i-1];
      end
    end
  end

  always_ff @(posedge clkpos1 or posedge rst) begin
    if (rst) begin
      r_ovf_err <= 1'b0;
    end else if (w_capture && w_full && !w_pop) begin
      r_ovf_err <= 1'b1;
    end
  end

  xor16b_result_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clkpos1 (clkpos1),
    .rst     (rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  (w_entry),
    .o_head  (w_head),
    .o_count (w_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign out_valid = !w_empty;
  assign out_data  = WIDTH'(w_head.data);
  assign out_zero  = w_head.zero;
  assign ovf_err   = r_ovf_err;

`ifdef XOR16B_RESULT_PARITY_EN
  assign out_parity = w_head.parity;
`else
  logic w_unused_parity;
  assign w_unused_parity = w_head.parity;
  assign out_parity      = 1'b0;
`endif

endmodule
